inst_fetch: RTL and testbench

Front end of the fetch stage. Owns the PC, issues in-order word requests to the instruction memory/icache, and tracks up to MAX_OUTSTANDING in-flight requests. Returns instructions through a small response buffer to registered outputs that drive the IF/ID pipeline register. Honours stall, branch redirect and flush from downstream, and discards wrong-path responses.

---
 rtl/inst_fetch.sv | 187 ++++++++++++++++++
 tb/tb_inst_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Fetch-stage front end: owns the PC, issues in-order word requests to the icache
// and returns instructions through a small response buffer to the IF/ID outputs.
module inst_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_ready_i,
  input  logic        icache_rvalid_i,
  input  logic [31:0] icache_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_inst_valid_o
);
  localparam int DEPTH = MAX_OUTSTANDING;
  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [31:0]      pc_reg, pc_next;
  logic [CNT_W-1:0] in_flight_reg, in_flight_next;
  logic [PTR_W-1:0] if_head_reg, if_tail_reg;
  logic [DEPTH-1:0] if_kill_reg;
  logic [31:0]      if_pc_mem [DEPTH];

  logic [CNT_W-1:0] rb_count_reg, rb_count_next;
  logic [PTR_W-1:0] rb_head_reg, rb_tail_reg;
  logic [31:0]      rb_pc_mem   [DEPTH];
  logic [31:0]      rb_inst_mem [DEPTH];

  logic [31:0]      out_pc_reg, out_pc_next;
  logic [31:0]      out_inst_reg, out_inst_next;
  logic             out_valid_reg, out_valid_next;

  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             credit, req, accept, resp;
  logic             head_kill, live_resp;
  logic [31:0]      head_pc;
  logic             rb_push, rb_pop, rb_nonempty;

  assign redirect    = flush_i | branch_flag_i;
  assign redirect_pc = flush_i ? {flush_pc_i[31:2], 2'b00} : {branch_target_i[31:2], 2'b00};

  // Killed in-flight entries still hold a credit until their response returns.
  assign credit  = ({1'b0, in_flight_reg} + {1'b0, rb_count_reg}) < CREDIT_LIMIT;
  assign req     = credit & ~stall_i & ~redirect;
  assign accept  = req & icache_ready_i;
  assign resp    = icache_rvalid_i & (in_flight_reg != '0);

  assign head_kill   = if_kill_reg[if_head_reg];
  assign head_pc     = if_pc_mem[if_head_reg];
  assign live_resp   = resp & ~head_kill & ~redirect;
  assign rb_nonempty = (rb_count_reg != '0);

  // A live response bypasses the buffer only when the buffer is empty and the output loads.
  assign rb_pop  = ~redirect & ~stall_i & rb_nonempty;
  assign rb_push = live_resp & (stall_i | rb_nonempty);

  assign icache_req_o    = req;
  assign icache_addr_o   = pc_reg;
  assign if_pc_o         = out_pc_reg;
  assign if_inst_o       = out_inst_reg;
  assign if_inst_valid_o = out_valid_reg;

  always_comb begin
    pc_next = pc_reg;
    if (redirect) begin
      pc_next = redirect_pc;
    end else if (accept) begin
      pc_next = pc_reg + 32'd4;
    end

    in_flight_next = in_flight_reg;
    case ({accept, resp})
      2'b10:   in_flight_next = in_flight_reg + CNT_W'(1);
      2'b01:   in_flight_next = in_flight_reg - CNT_W'(1);
      default: in_flight_next = in_flight_reg;
    endcase

    rb_count_next = rb_count_reg;
    if (redirect) begin
      rb_count_next = '0;
    end else if (rb_push && !rb_pop) begin
      rb_count_next = rb_count_reg + CNT_W'(1);
    end else if (rb_pop && !rb_push) begin
      rb_count_next = rb_count_reg - CNT_W'(1);
    end

    out_pc_next    = out_pc_reg;
    out_inst_next  = out_inst_reg;
    out_valid_next = out_valid_reg;
    if (redirect) begin
      out_pc_next    = '0;
      out_inst_next  = '0;
      out_valid_next = 1'b0;
    end else if (!stall_i) begin
      if (rb_nonempty) begin
        out_pc_next    = rb_pc_mem[rb_head_reg];
        out_inst_next  = rb_inst_mem[rb_head_reg];
        out_valid_next = 1'b1;
      end else if (live_resp) begin
        out_pc_next    = head_pc;
        out_inst_next  = icache_rdata_i;
        out_valid_next = 1'b1;
      end else begin
        out_pc_next    = '0;
        out_inst_next  = '0;
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg        <= RESET_PC;
      in_flight_reg <= '0;
      if_head_reg   <= '0;
      if_tail_reg   <= '0;
      rb_count_reg  <= '0;
      rb_head_reg   <= '0;
      rb_tail_reg   <= '0;
      out_pc_reg    <= '0;
      out_inst_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      in_flight_reg <= in_flight_next;
      if (accept) begin
        if_tail_reg <= ptr_inc(if_tail_reg);
      end
      if (resp) begin
        if_head_reg <= ptr_inc(if_head_reg);
      end
      rb_count_reg <= rb_count_next;
      if (redirect) begin
        rb_head_reg <= '0;
        rb_tail_reg <= '0;
      end else begin
        if (rb_push) begin
          rb_tail_reg <= ptr_inc(rb_tail_reg);
        end
        if (rb_pop) begin
          rb_head_reg <= ptr_inc(rb_head_reg);
        end
      end
      out_pc_reg    <= out_pc_next;
      out_inst_reg  <= out_inst_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Redirect marks every slot stale; a slot is revived only when a new request claims it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_kill_reg <= '0;
    end else if (redirect) begin
      if_kill_reg <= '1;
    end else if (accept) begin
      if_kill_reg[if_tail_reg] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if_pc_mem[if_tail_reg] <= pc_reg;
    end
    if (rb_push) begin
      rb_pc_mem[rb_tail_reg]   <= head_pc;
      rb_inst_mem[rb_tail_reg] <= icache_rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: random icache timing and redirects checked against a
// transaction-level model of credits, killed requests and the output PC stream.
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int          MAX      = 2;
  localparam logic [31:0] K        = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i, branch_flag_i, stall_i;
  logic [31:0] flush_pc_i, branch_target_i;
  logic        icache_req_o, icache_ready_i, icache_rvalid_i;
  logic [31:0] icache_addr_o, icache_rdata_i;
  logic [31:0] if_pc_o, if_inst_o;
  logic        if_inst_valid_o;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .stall_i(stall_i),
    .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
    .icache_ready_i(icache_ready_i), .icache_rvalid_i(icache_rvalid_i),
    .icache_rdata_i(icache_rdata_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_inst_valid_o(if_inst_valid_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: requests the icache still owes (with a live flag), count of live
  // responses received but not yet presented, next request PC, next output PC.
  logic [31:0] addr_q[$];
  bit          live_q[$];
  int          buffered;
  logic [31:0] model_pc, next_out_pc;
  logic [31:0] exp_pc, exp_inst;
  logic        exp_valid;
  bit          stray;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    addr_q.delete();
    live_q.delete();
    buffered    = 0;
    model_pc    = RESET_PC;
    next_out_pc = RESET_PC;
    exp_pc      = '0;
    exp_inst    = '0;
    exp_valid   = 1'b0;
  endtask

  // Called just after a falling edge: drive one cycle, check request side, model the
  // rising edge, then check the registered outputs at the next falling edge.
  task automatic step(input bit st, input bit br, input logic [31:0] bt,
                      input bit fl, input logic [31:0] ft,
                      input int rdy_pct, input int rsp_pct);
    bit          redir, exp_req, resp, live, acc, rdy;
    logic [31:0] tgt;
    stall_i         = st;
    branch_flag_i   = br;
    branch_target_i = bt;
    flush_i         = fl;
    flush_pc_i      = ft;
    rdy             = (int'($urandom_range(0, 99)) < rdy_pct);
    icache_ready_i  = rdy;
    resp            = 1'b0;
    if (stray) begin
      icache_rvalid_i = 1'b1;
      icache_rdata_i  = $urandom;
    end else if (addr_q.size() > 0 && int'($urandom_range(0, 99)) < rsp_pct) begin
      resp            = 1'b1;
      icache_rvalid_i = 1'b1;
      icache_rdata_i  = addr_q[0] ^ K;
    end else begin
      icache_rvalid_i = 1'b0;
      icache_rdata_i  = $urandom;
    end
    #1;
    redir   = fl | br;
    exp_req = ((addr_q.size() + buffered) < MAX) && !st && !redir;
    chk("req", 32'(icache_req_o), 32'(exp_req));
    chk("addr", icache_addr_o, model_pc);

    live = 1'b0;
    if (resp) begin
      live = live_q[0] && !redir;
      void'(addr_q.pop_front());
      void'(live_q.pop_front());
    end
    acc = exp_req && rdy;
    if (acc) begin
      addr_q.push_back(model_pc);
      live_q.push_back(1'b1);
      model_pc = model_pc + 32'd4;
    end
    if (redir) begin
      tgt = fl ? ft : bt;
      tgt[1:0] = 2'b00;
      foreach (live_q[i]) live_q[i] = 1'b0;
      buffered    = 0;
      model_pc    = tgt;
      next_out_pc = tgt;
      exp_valid   = 1'b0;
      exp_pc      = '0;
      exp_inst    = '0;
    end else if (st) begin
      if (live) buffered++;
    end else if (buffered > 0 || live) begin
      exp_valid   = 1'b1;
      exp_pc      = next_out_pc;
      exp_inst    = next_out_pc ^ K;
      next_out_pc = next_out_pc + 32'd4;
      if (buffered > 0 && !live) buffered--;
    end else begin
      exp_valid = 1'b0;
      exp_pc    = '0;
      exp_inst  = '0;
    end

    @(posedge clk);
    @(negedge clk);
    chk("valid", 32'(if_inst_valid_o), 32'(exp_valid));
    chk("if_pc", if_pc_o, exp_pc);
    chk("if_inst", if_inst_o, exp_inst);
  endtask

  bit          r_st, r_br, r_fl;
  logic [31:0] r_bt, r_ft;
  int          r_rdy, r_rsp;

  initial begin
    flush_i = 0; flush_pc_i = '0; branch_flag_i = 0; branch_target_i = '0;
    stall_i = 0; icache_ready_i = 0; icache_rvalid_i = 0; icache_rdata_i = '0;
    stray = 0;
    reset_model();

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(if_inst_valid_o), 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_inst", if_inst_o, 32'd0);
    chk("rst_addr", icache_addr_o, RESET_PC);
    rst = 1'b0;

    // Streaming with single-cycle responses.
    repeat (8) step(0, 0, '0, 0, '0, 100, 100);

    // Two in flight, then a four-cycle stall while both responses land in the buffer.
    repeat (3) step(0, 0, '0, 0, '0, 100, 0);
    repeat (4) step(1, 0, '0, 0, '0, 100, 100);
    repeat (5) step(0, 0, '0, 0, '0, 100, 100);

    // Branch with two stale requests outstanding; unaligned target.
    repeat (3) step(0, 0, '0, 0, '0, 100, 0);
    step(0, 1, 32'h1c000102, 0, '0, 100, 100);
    repeat (5) step(0, 0, '0, 0, '0, 100, 100);

    // Flush beats a simultaneous branch, and beats a stall.
    step(0, 1, 32'h1c000200, 1, 32'h1c008000, 100, 100);
    repeat (4) step(0, 0, '0, 0, '0, 100, 100);
    step(1, 0, '0, 1, 32'h1c00a000, 100, 100);
    repeat (4) step(0, 0, '0, 0, '0, 100, 100);

    // icache not ready for three cycles, then PC wrap past 0xFFFFFFFC.
    repeat (3) step(0, 0, '0, 0, '0, 0, 100);
    step(0, 1, 32'hFFFFFFFE, 0, '0, 100, 100);
    repeat (4) step(0, 0, '0, 0, '0, 100, 100);

    // Asynchronous reset with a valid output and buffered responses.
    repeat (4) step(0, 0, '0, 0, '0, 100, 100);
    repeat (2) step(1, 0, '0, 0, '0, 100, 100);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(if_inst_valid_o), 32'd0);
    chk("arst_pc", if_pc_o, 32'd0);
    chk("arst_inst", if_inst_o, 32'd0);
    chk("arst_addr", icache_addr_o, RESET_PC);
    reset_model();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray = 1;
    repeat (2) step(0, 0, '0, 0, '0, 0, 0);
    stray = 0;
    repeat (6) step(0, 0, '0, 0, '0, 100, 100);

    // Random mix of icache timing, stalls and redirects.
    repeat (1500) begin
      r_st  = (int'($urandom_range(0, 99)) < 15);
      r_br  = (int'($urandom_range(0, 99)) < 6);
      r_fl  = (int'($urandom_range(0, 99)) < 3);
      r_bt  = $urandom;
      r_ft  = $urandom;
      r_rdy = int'($urandom_range(30, 100));
      r_rsp = int'($urandom_range(30, 100));
      step(r_st, r_br, r_bt, r_fl, r_ft, r_rdy, r_rsp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
